// File: rtl/coord_box_writer_pkg.sv
// Shared types and helpers for the coordinate marker writer.
//   state_e    : update sequencer states
//   PIX_BYTES  : bytes per RGB565 pixel
//   clamp_coord: unsigned min(v, lim), truncated to 16 bits
//   pix_addr   : byte address of pixel (px+c, py+r) in a row-major frame
package coord_box_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ERASE = 2'd1,
      DRAW  = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [31:0] PIX_BYTES = 32'd2;

   // lim always fits the frame, so the 16-bit result is exact
   function automatic logic [15:0] clamp_coord(input logic [31:0] v, input logic [31:0] lim);
      return (v > lim) ? lim[15:0] : v[15:0];
   endfunction

   function automatic logic [31:0] pix_addr(input logic [31:0] base,
                                            input logic [31:0] hres,
                                            input logic [15:0] px,
                                            input logic [15:0] py,
                                            input logic [4:0]  r,
                                            input logic [4:0]  c);
      logic [31:0] row;
      logic [31:0] col;
      row = {16'd0, py} + {27'd0, r};
      col = {16'd0, px} + {27'd0, c};
      return base + (row * hres + col) * PIX_BYTES;
   endfunction

endpackage

// File: rtl/coord_box_writer_if.sv
// Avalon-MM write-master bundle for the frame-buffer port.
//   avm_address     : byte address of the pixel
//   avm_write       : write request
//   avm_writedata   : RGB565 pixel
//   avm_byteenable  : both bytes enabled
//   avm_waitrequest : slave stall
interface coord_box_writer_if;
   logic [31:0] avm_address;
   logic        avm_write;
   logic [15:0] avm_writedata;
   logic [1:0]  avm_byteenable;
   logic        avm_waitrequest;

   modport master (
      output avm_address, avm_write, avm_writedata, avm_byteenable,
      input  avm_waitrequest
   );

   modport slave (
      input  avm_address, avm_write, avm_writedata, avm_byteenable,
      output avm_waitrequest
   );
endinterface

// File: rtl/coord_box_writer_stabilizer.sv
// Registers the raw coordinate pair, counts how long it has stayed put and
// clamps it so a full marker fits inside the frame.
//   clk, reset       : clock, async active-high reset
//   x_coord, y_coord : raw PIO coordinates
//   nx, ny           : clamped version of the registered pair
//   stable           : one-cycle pulse once the pair has been identical for
//                      STABLE_CYCLES samples
import coord_box_pkg::*;

module coord_stabilizer #(
   parameter int H_RES         = 640,
   parameter int V_RES         = 480,
   parameter int BOX           = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] x_coord,
   input  logic [31:0] y_coord,
   output logic [15:0] nx,
   output logic [15:0] ny,
   output logic        stable
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   logic [31:0]   x_q, y_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // Saturating one above the stable value makes "stable" a single pulse per
   // settled pair, so a held pair cannot relaunch after it has been drawn.
   always_comb begin
      cnt_d = cnt_q;
      if (x_coord != x_q || y_coord != y_q)
         cnt_d = '0;
      else if (cnt_q != CW'(STABLE_CYCLES))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q   <= '0;
         y_q   <= '0;
         cnt_q <= '0;
      end else begin
         x_q   <= x_coord;
         y_q   <= y_coord;
         cnt_q <= cnt_d;
      end
   end

   assign stable = (cnt_q == CW'(STABLE_CYCLES - 1));
   assign nx     = clamp_coord(x_q, 32'(H_RES - BOX));
   assign ny     = clamp_coord(y_q, 32'(V_RES - BOX));

endmodule

// File: rtl/coord_box_writer.sv
// Draws a BOX x BOX marker at the latest stable coordinate pair, erasing the
// previous marker first.
//   clk, reset         : clock, async active-high reset
//   x_coord, y_coord   : raw PIO coordinates
//   enable             : permits new pairs to launch an update
//   fg_color, bg_color : marker and erase colours (RGB565)
//   avm                : Avalon-MM write master to the frame buffer
//   busy               : update in progress
//   draw_count         : completed updates, wrapping
//
// state | meaning
// IDLE  | waiting for an enabled, stable, new position
// ERASE | repainting the previous marker in bg colour
// DRAW  | painting the new marker in fg colour
// DONE  | one cycle: commit position, bump draw_count
import coord_box_pkg::*;

module coord_box_writer #(
   parameter int          H_RES         = 640,
   parameter int          V_RES         = 480,
   parameter int          BOX           = 4,
   parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
   parameter int          STABLE_CYCLES = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [31:0]               x_coord,
   input  logic [31:0]               y_coord,
   input  logic                      enable,
   input  logic [15:0]               fg_color,
   input  logic [15:0]               bg_color,
   coord_box_writer_if.master        avm,
   output logic                      busy,
   output logic [15:0]               draw_count
);

   localparam logic [4:0] LAST = 5'(BOX - 1);

   logic [15:0] nx, ny;
   logic        stable;

   state_e      state_q, state_d;
   logic [4:0]  r_q, r_d, c_q, c_d;
   logic [15:0] px_q, px_d, py_q, py_d;
   logic [15:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic [15:0] fg_q, fg_d, bg_q, bg_d;
   logic        has_drawn_q, has_drawn_d;
   logic [15:0] draw_count_q, draw_count_d;

   coord_stabilizer #(
      .H_RES(H_RES), .V_RES(V_RES), .BOX(BOX), .STABLE_CYCLES(STABLE_CYCLES)
   ) u_stab (
      .clk(clk), .reset(reset), .x_coord(x_coord), .y_coord(y_coord),
      .nx(nx), .ny(ny), .stable(stable)
   );

   always_comb begin
      state_d      = state_q;
      r_d          = r_q;
      c_d          = c_q;
      px_d         = px_q;
      py_d         = py_q;
      cur_x_d      = cur_x_q;
      cur_y_d      = cur_y_q;
      fg_d         = fg_q;
      bg_d         = bg_q;
      has_drawn_d  = has_drawn_q;
      draw_count_d = draw_count_q;
      case (state_q)
         IDLE: begin
            if (enable && stable && (!has_drawn_q || nx != cur_x_q || ny != cur_y_q)) begin
               px_d    = nx;
               py_d    = ny;
               fg_d    = fg_color;
               bg_d    = bg_color;
               r_d     = '0;
               c_d     = '0;
               state_d = has_drawn_q ? ERASE : DRAW;
            end
         end
         ERASE, DRAW: begin
            if (!avm.avm_waitrequest) begin
               if (c_q == LAST) begin
                  c_d = '0;
                  if (r_q == LAST) begin
                     r_d     = '0;
                     state_d = (state_q == ERASE) ? DRAW : DONE;
                  end else begin
                     r_d = r_q + 5'd1;
                  end
               end else begin
                  c_d = c_q + 5'd1;
               end
            end
         end
         DONE: begin
            cur_x_d      = px_q;
            cur_y_d      = py_q;
            has_drawn_d  = 1'b1;
            draw_count_d = draw_count_q + 16'd1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         r_q          <= '0;
         c_q          <= '0;
         px_q         <= '0;
         py_q         <= '0;
         cur_x_q      <= '0;
         cur_y_q      <= '0;
         fg_q         <= '0;
         bg_q         <= '0;
         has_drawn_q  <= 1'b0;
         draw_count_q <= '0;
      end else begin
         state_q      <= state_d;
         r_q          <= r_d;
         c_q          <= c_d;
         px_q         <= px_d;
         py_q         <= py_d;
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         fg_q         <= fg_d;
         bg_q         <= bg_d;
         has_drawn_q  <= has_drawn_d;
         draw_count_q <= draw_count_d;
      end
   end

   // Bus outputs decode straight from registered state, so they hold
   // unchanged through a stall and drop to idle values the moment reset hits.
   always_comb begin
      avm.avm_write     = 1'b0;
      avm.avm_address   = '0;
      avm.avm_writedata = '0;
      case (state_q)
         ERASE: begin
            avm.avm_write     = 1'b1;
            avm.avm_address   = pix_addr(BASE_ADDR, 32'(H_RES), cur_x_q, cur_y_q, r_q, c_q);
            avm.avm_writedata = bg_q;
         end
         DRAW: begin
            avm.avm_write     = 1'b1;
            avm.avm_address   = pix_addr(BASE_ADDR, 32'(H_RES), px_q, py_q, r_q, c_q);
            avm.avm_writedata = fg_q;
         end
         default: ;
      endcase
   end

   assign avm.avm_byteenable = 2'b11;
   assign busy               = (state_q != IDLE);
   assign draw_count         = draw_count_q;

endmodule

// File: tb/tb_coord_box_writer.sv
module tb_coord_box_writer;

   localparam int H = 640;
   localparam int V = 480;
   localparam int B = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] x_coord = '0;
   logic [31:0] y_coord = '0;
   logic        enable = 1'b0;
   logic [15:0] fg_color = 16'hF800;
   logic [15:0] bg_color = 16'h001F;
   logic        busy;
   logic [15:0] draw_count;

   coord_box_writer_if avm_if();

   coord_box_writer dut (
      .clk(clk), .reset(reset), .x_coord(x_coord), .y_coord(y_coord),
      .enable(enable), .fg_color(fg_color), .bg_color(bg_color),
      .avm(avm_if), .busy(busy), .draw_count(draw_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [15:0] data;
   } wr_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   wr_t         exp_q[$];
   logic [31:0] acc_log[$];
   int          stall_seen = 0;
   int          stall_left = 0;
   int          stall_pos  = 0;
   int          stall_base = 0;

   // model state: what the frame-buffer marker should be after each update
   bit          m_has_drawn = 1'b0;
   logic [31:0] m_cx = '0, m_cy = '0;
   int          m_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_box(input logic [31:0] px, input logic [31:0] py, input logic [15:0] col);
      for (int r = 0; r < B; r++)
         for (int c = 0; c < B; c++) begin
            wr_t w;
            w.addr = ((py + 32'(r)) * H + px + 32'(c)) * 2;
            w.data = col;
            exp_q.push_back(w);
         end
   endtask

   // returns number of writes expected for this pair (0 if no update)
   task automatic model_update(input logic [31:0] x, input logic [31:0] y, input bit en, output int nwr);
      logic [31:0] cx, cy;
      cx  = (x > 32'(H - B)) ? 32'(H - B) : x;
      cy  = (y > 32'(V - B)) ? 32'(V - B) : y;
      nwr = 0;
      if (en && (!m_has_drawn || cx != m_cx || cy != m_cy)) begin
         if (m_has_drawn) begin
            push_box(m_cx, m_cy, bg_color);
            nwr += B * B;
         end
         push_box(cx, cy, fg_color);
         nwr += B * B;
         m_cx = cx;
         m_cy = cy;
         m_has_drawn = 1'b1;
         m_count++;
      end
   endtask

   task automatic apply(input logic [31:0] x, input logic [31:0] y, input bit en);
      @(posedge clk);
      #1;
      x_coord = x;
      y_coord = y;
      enable  = en;
   endtask

   task automatic wait_update(input int nwr, input int base, input int extra, output int bcnt);
      bit seen;
      seen = 1'b0;
      bcnt = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = busy;
      end
      if (nwr > 0) begin
         chk("busy_rise", 32'(seen), 32'd1);
         if (seen) begin
            chk("first_write_with_busy", 32'(avm_if.avm_write), 32'd1);
            bcnt = 1;
            for (int i = 0; i < 300; i++) begin
               @(negedge clk);
               if (!busy) break;
               bcnt++;
            end
            chk("busy_cycles", 32'(bcnt), 32'(nwr + 1 + extra));
         end
      end else begin
         chk("no_busy", 32'(seen), 32'd0);
      end
      repeat (3) @(negedge clk);
      chk("writes_accepted", 32'(acc_log.size() - base), 32'(nwr));
      chk("expected_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("draw_count", {16'd0, draw_count}, 32'(m_count));
   endtask

   task automatic run_update(input logic [31:0] x, input logic [31:0] y, input bit en,
                             input int extra, output int base, output int bcnt);
      int nwr;
      apply(x, y, en);
      base = acc_log.size();
      model_update(x, y, en, nwr);
      wait_update(nwr, base, extra, bcnt);
   endtask

   // compare process: every accepted write must match the model in order,
   // and a stalled write must not change until accepted
   initial begin
      logic [31:0] h_addr;
      logic [15:0] h_data;
      bit          h_valid;
      h_valid = 1'b0;
      h_addr  = '0;
      h_data  = '0;
      forever begin
         @(negedge clk);
         if (!reset && avm_if.avm_write) begin
            if (h_valid) begin
               chk("hold_addr", avm_if.avm_address, h_addr);
               chk("hold_data", {16'd0, avm_if.avm_writedata}, {16'd0, h_data});
            end
            if (avm_if.avm_waitrequest) begin
               stall_seen++;
               h_valid = 1'b1;
               h_addr  = avm_if.avm_address;
               h_data  = avm_if.avm_writedata;
            end else begin
               h_valid = 1'b0;
               chk("byteenable", {30'd0, avm_if.avm_byteenable}, 32'd3);
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL extra_write: got address %h, no write expected", avm_if.avm_address);
               end else begin
                  wr_t e;
                  e = exp_q.pop_front();
                  chk("wr_addr", avm_if.avm_address, e.addr);
                  chk("wr_data", {16'd0, avm_if.avm_writedata}, {16'd0, e.data});
               end
               acc_log.push_back(avm_if.avm_address);
            end
         end else begin
            h_valid = 1'b0;
         end
      end
   end

   // slave model: stalls a chosen write of an update for stall_left cycles
   initial begin
      avm_if.avm_waitrequest = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (stall_left > 0 && avm_if.avm_write && (acc_log.size() - stall_base) == stall_pos) begin
            avm_if.avm_waitrequest = 1'b1;
            stall_left--;
         end else begin
            avm_if.avm_waitrequest = 1'b0;
         end
      end
   end

   initial begin
      int base, bcnt, s0, nwr;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_write", 32'(avm_if.avm_write), 32'd0);
      chk("rst_address", avm_if.avm_address, 32'd0);
      chk("rst_writedata", {16'd0, avm_if.avm_writedata}, 32'd0);
      chk("rst_byteenable", {30'd0, avm_if.avm_byteenable}, 32'd3);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_draw_count", {16'd0, draw_count}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (8) @(posedge clk);

      // 1: first draw at (100,50)
      run_update(32'd100, 32'd50, 1'b1, 0, base, bcnt);
      chk("t1_busy17", 32'(bcnt), 32'd17);
      if (acc_log.size() >= base + 16) begin
         chk("t1_first_addr", acc_log[base], 32'h0000FAC8);
         chk("t1_last_addr", acc_log[base + 15], 32'h0000FAC8 + 32'd3846);
      end
      chk("t1_count", {16'd0, draw_count}, 32'd1);

      // 2: move one pixel right -> erase then draw
      run_update(32'd101, 32'd50, 1'b1, 0, base, bcnt);
      chk("t2_busy33", 32'(bcnt), 32'd33);
      if (acc_log.size() >= base + 32) begin
         chk("t2_erase_first", acc_log[base], 32'h0000FAC8);
         chk("t2_draw_first", acc_log[base + 16], 32'h0000FACA);
      end
      chk("t2_count", {16'd0, draw_count}, 32'd2);

      // 3: out-of-frame coordinates clamp to (636,476)
      fg_color = 16'h07E0;
      run_update(32'd700, 32'hFFFF_FFFF, 1'b1, 0, base, bcnt);
      if (acc_log.size() >= base + 32)
         chk("t3_clamped_addr", acc_log[base + 16], 32'h000950F8);

      // 4: 3-cycle stall on the 5th write of the update
      bg_color   = 16'hAAAA;
      stall_base = acc_log.size();
      stall_pos  = 4;
      stall_left = 3;
      s0         = stall_seen;
      run_update(32'd320, 32'd240, 1'b1, 3, base, bcnt);
      chk("t4_stall_cycles", 32'(stall_seen - s0), 32'd3);

      // 5a: short glitch back to the same pair -> nothing
      apply(32'd200, 32'd240, 1'b1);
      repeat (1) @(posedge clk);
      run_update(32'd320, 32'd240, 1'b1, 0, base, bcnt);
      chk("t5_count_unchanged", {16'd0, draw_count}, 32'd4);
      // 5b: new stable pair with enable low -> nothing
      run_update(32'd300, 32'd200, 1'b0, 0, base, bcnt);

      // 6: reset after 7 accepted writes, then draw-only relaunch
      apply(32'd10, 32'd20, 1'b1);
      base = acc_log.size();
      model_update(32'd10, 32'd20, 1'b1, nwr);
      for (int i = 0; i < 200 && (acc_log.size() - base) < 7; i++) @(negedge clk);
      chk("t6_acc_before_reset", 32'(acc_log.size() - base), 32'd7);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("t6_write_low", 32'(avm_if.avm_write), 32'd0);
      chk("t6_busy_low", 32'(busy), 32'd0);
      chk("t6_addr_zero", avm_if.avm_address, 32'd0);
      chk("t6_count_zero", {16'd0, draw_count}, 32'd0);
      exp_q.delete();
      m_has_drawn = 1'b0;
      m_count     = 0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      base = acc_log.size();
      model_update(32'd10, 32'd20, 1'b1, nwr);
      chk("t6_model_draw_only", 32'(nwr), 32'd16);
      wait_update(nwr, base, 0, bcnt);
      chk("t6_busy17", 32'(bcnt), 32'd17);
      if (acc_log.size() >= base + 1)
         chk("t6_first_addr", acc_log[base], 32'h00006414);
      chk("t6_count", {16'd0, draw_count}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1);
   end

endmodule
